// File: rtl/seg7_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_pkg : segment patterns and capture state type | rev 1.0
// ------------------------------------------------------------------
package seg7_pkg;

  // Active-low patterns, bit0 = seg a .. bit6 = seg g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    S_TRACK = 1'b0,
    S_HOLD  = 1'b1
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_capture_if.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_capture_if : segment inputs and decoded outputs | rev 1.0
// ------------------------------------------------------------------
interface seg7_capture_if;
  logic [6:0] leds1;
  logic [6:0] leds2;
  logic [4:0] value;
  logic       valid;
  logic       update;
  logic       err;

  modport master (
    output leds1, leds2,
    input  value, valid, update, err
  );

  modport slave (
    input  leds1, leds2,
    output value, valid, update, err
  );
endinterface
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_digit_decode : active-low pattern -> digit + hit | rev 1.0
// ------------------------------------------------------------------
module seg7_digit_decode (
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       hit
);
  import seg7_pkg::*;

  always_comb begin
    digit = 4'd0;
    hit   = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: hit   = 1'b0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_capture : debounced seven-segment pair -> signed value | rev 1.0
// ------------------------------------------------------------------
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  seg7_capture_if.slave  bus
);
  import seg7_pkg::*;

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Pair packing: [13:7] = sign digit, [6:0] = magnitude digit
  logic [13:0]      sync1_q, sync1_d;
  logic [13:0]      sync2_q, sync2_d;
  logic [13:0]      snap_q,  snap_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  cap_state_t       state_q, state_d;
  logic [4:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             err_q,   err_d;

  logic [3:0] mag_digit;
  logic       mag_hit;
  logic       is_neg;
  logic       sign_ok;
  logic       legal;
  logic [4:0] decoded;

  seg7_digit_decode u_mag_decode (
    .pattern (snap_q[6:0]),
    .digit   (mag_digit),
    .hit     (mag_hit)
  );

  always_comb begin
    is_neg  = (snap_q[13:7] == SEG_MINUS);
    sign_ok = is_neg || (snap_q[13:7] == SEG_0);
    // "-0" is rejected so every legal display has exactly one encoding
    legal   = sign_ok && mag_hit && !(is_neg && (mag_digit == 4'd0));
    decoded = is_neg ? (5'd0 - {1'b0, mag_digit}) : {1'b0, mag_digit};
  end

  always_comb begin
    sync1_d  = {bus.leds1, bus.leds2};
    sync2_d  = sync1_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    value_d  = value_q;
    valid_d  = valid_q;
    err_d    = err_q;
    update_d = 1'b0;

    if (sync2_q != snap_q) begin
      snap_d  = sync2_q;
      cnt_d   = '0;
      state_d = S_TRACK;
    end else if (state_q == S_TRACK) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_HOLD;
        if (legal) begin
          err_d    = 1'b0;
          valid_d  = 1'b1;
          value_d  = decoded;
          update_d = (decoded != value_q) || !valid_q;
        end else begin
          err_d   = 1'b1;
          valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= {SEG_BLANK, SEG_BLANK};
      sync2_q  <= {SEG_BLANK, SEG_BLANK};
      snap_q   <= {SEG_BLANK, SEG_BLANK};
      cnt_q    <= '0;
      state_q  <= S_TRACK;
      value_q  <= 5'd0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.update = update_q;
  assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_seg7_capture : directed bench with update-value scoreboard | rev 1.0
// ------------------------------------------------------------------
module tb_seg7_capture;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_upd = 0;
  logic prev_upd = 1'b0;
  logic [4:0] exp_q[$];

  seg7_capture_if bus ();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every update pulse must match the next queued value
  always @(negedge clk) begin
    if (reset_n && bus.update === 1'b1) begin
      n_upd++;
      if (exp_q.size() == 0) begin
        check("unexpected_update", {27'd0, bus.value}, 32'hFFFF_FFFF);
      end else begin
        check("update_value", {27'd0, bus.value}, {27'd0, exp_q.pop_front()});
      end
      check("update_single_cycle", {31'd0, prev_upd}, 32'd0);
    end
    prev_upd = reset_n && (bus.update === 1'b1);
  end

  task automatic drive(input logic [6:0] l1, input logic [6:0] l2);
    bus.leds1 = l1;
    bus.leds2 = l2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  // Inputs already settled before edge E0; pulse is seen after E6
  task automatic check_latency(input string tag, input logic [4:0] exp_val);
    repeat (6) @(negedge clk);
    check({tag, "_early"}, {31'd0, bus.update}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.update}, 32'd1);
    check({tag, "_value"}, {27'd0, bus.value}, {27'd0, exp_val});
    check({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    check({tag, "_after"}, {31'd0, bus.update}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(7'h7F, 7'h7F);
    repeat (3) @(negedge clk);
    check("rst_value",  {27'd0, bus.value}, 32'd0);
    check("rst_valid",  {31'd0, bus.valid}, 32'd0);
    check("rst_update", {31'd0, bus.update}, 32'd0);
    check("rst_err",    {31'd0, bus.err}, 32'd0);

    // 1: +2, exact latency
    drive(7'h40, 7'h24);
    exp_q.push_back(5'b00010);
    reset_n = 1'b1;
    check_latency("t1", 5'b00010);

    // 2: -9
    exp_q.push_back(5'b10111);
    drive(7'h3F, 7'h10);
    wait_drain("t2", 20);
    repeat (2) @(negedge clk);
    check("t2_value", {27'd0, bus.value}, {27'd0, 5'b10111});
    check("t2_valid", {31'd0, bus.valid}, 32'd1);

    // 3: short glitch on magnitude, then back to the same display
    begin
      int upd_before;
      upd_before = n_upd;
      drive(7'h3F, 7'h00);
      repeat (3) @(negedge clk);
      drive(7'h3F, 7'h10);
      repeat (15) @(negedge clk);
      check("t3_no_update", n_upd, upd_before);
      check("t3_value", {27'd0, bus.value}, {27'd0, 5'b10111});
      check("t3_valid", {31'd0, bus.valid}, 32'd1);
    end

    // 4: "-0" is illegal, then +1
    drive(7'h3F, 7'h40);
    repeat (12) @(negedge clk);
    check("t4_err",   {31'd0, bus.err}, 32'd1);
    check("t4_valid", {31'd0, bus.valid}, 32'd0);
    check("t4_value", {27'd0, bus.value}, {27'd0, 5'b10111});
    exp_q.push_back(5'b00001);
    drive(7'h40, 7'h79);
    wait_drain("t4", 20);
    repeat (2) @(negedge clk);
    check("t4b_err",   {31'd0, bus.err}, 32'd0);
    check("t4b_value", {27'd0, bus.value}, 32'd1);

    // 5: blank, then the same +1 again pulses because valid dropped
    drive(7'h7F, 7'h7F);
    repeat (10) @(negedge clk);
    check("t5_err",   {31'd0, bus.err}, 32'd1);
    check("t5_valid", {31'd0, bus.valid}, 32'd0);
    check("t5_value", {27'd0, bus.value}, 32'd1);
    exp_q.push_back(5'b00001);
    drive(7'h40, 7'h79);
    wait_drain("t5", 20);
    repeat (2) @(negedge clk);
    check("t5b_valid", {31'd0, bus.valid}, 32'd1);
    check("t5b_err",   {31'd0, bus.err}, 32'd0);

    // 6: reset mid-settle of -1, then fresh decode
    drive(7'h3F, 7'h79);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_value",  {27'd0, bus.value}, 32'd0);
    check("t6_rst_valid",  {31'd0, bus.valid}, 32'd0);
    check("t6_rst_update", {31'd0, bus.update}, 32'd0);
    check("t6_rst_err",    {31'd0, bus.err}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(5'b11111);
    reset_n = 1'b1;
    check_latency("t6", 5'b11111);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
